// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Merges regfile writeback traffic from two producers (A: ALU/execute,
// B: load/long-latency) into one registered regfile write port. Each
// producer is buffered in its own FIFO; the FIFOs are served round-robin,
// one write per cycle. Writes to x0 are consumed without raising rf_we.
//
// Optional feature: define WBARB_PEND_EN to build per-register pending-write
// counters that drive pend_mask. Without it pend_mask is tied to zero.
module wb_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [NUM_REGS-1:0]   pend_mask
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Per-port FIFO state; index 0 is port A, index 1 is port B.
  logic [1:0]       valid;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       not_empty;
  logic [1:0]       ready_q;
  logic [1:0]       ready_d;
  wb_entry_t        in_ent  [2];
  wb_entry_t        head    [2];
  wb_entry_t        mem_q   [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q  [2];
  logic [PTR_W-1:0] rptr_q  [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  prio_e                 prio_q;
  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;

  assign valid          = {b_valid, a_valid};
  assign in_ent[PORT_A] = {a_rd, a_data};
  assign in_ent[PORT_B] = {b_rd, b_data};

  assign a_ready  = ready_q[PORT_A];
  assign b_ready  = ready_q[PORT_B];
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;

  // FIFO status: occupancy, accepted pushes and the head entry of each port.
  // NOTE: every output of an always_comb is assigned on every path (here by
  // the loop covering all ports), so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      not_empty[p] = (cnt_q[p] != '0);
      push[p]      = valid[p] && ready_q[p];
      head[p]      = mem_q[p][rptr_q[p]];
    end
  end

  // Round-robin grant: the priority holder wins under contention, a lone
  // non-empty FIFO always wins.
  always_comb begin
    pop         = '0;
    pop[PORT_A] = not_empty[PORT_A] && (!not_empty[PORT_B] || prio_q == PRIO_A);
    pop[PORT_B] = not_empty[PORT_B] && (!not_empty[PORT_A] || prio_q == PRIO_B);
  end

  // Next occupancy and next ready; a full FIFO stays not-ready even while
  // it pops, so there is no pass-through path from pop to ready.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cnt_d[p]   = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      ready_d[p] = (cnt_d[p] != FULL_CNT);
    end
  end

  // FIFO pointers, occupancy and registered ready.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
      ready_q <= 2'b11;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wptr_q[p] <= wptr_q[p] + PTR_W'(1);
        if (pop[p])  rptr_q[p] <= rptr_q[p] + PTR_W'(1);
        cnt_q[p] <= cnt_d[p];
      end
      ready_q <= ready_d;
    end
  end

  // FIFO storage writes at the tail.
  // NOTE: storage is not reset; entries are only visible once counted, so
  // stale contents after reset can never be issued.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wptr_q[p]] <= in_ent[p];
    end
  end

  // Registered regfile write port and round-robin priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      prio_q     <= PRIO_A;
    end else if (pop[PORT_A]) begin
      rf_we_q    <= (head[PORT_A].rd != '0);
      rf_addr_q  <= head[PORT_A].rd;
      rf_wdata_q <= head[PORT_A].data;
      prio_q     <= PRIO_B;
    end else if (pop[PORT_B]) begin
      rf_we_q    <= (head[PORT_B].rd != '0);
      rf_addr_q  <= head[PORT_B].rd;
      rf_wdata_q <= head[PORT_B].data;
      prio_q     <= PRIO_A;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

`ifdef WBARB_PEND_EN
  // Each counter covers up to FIFO_DEPTH entries in each FIFO.
  localparam int PCNT_W = $clog2(2 * FIFO_DEPTH + 1);

  logic [PCNT_W-1:0]   pcnt_q [NUM_REGS];
  logic [PCNT_W-1:0]   pcnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Pending counts: +1 per accepted push to r, -1 per pop of r; x0 never pends.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pcnt_d[r] = '0;
      pend_d[r] = 1'b0;
      if (r != 0) begin
        pcnt_d[r] = pcnt_q[r]
                  + PCNT_W'(push[PORT_A] && (in_ent[PORT_A].rd == ADDR_WIDTH'(r)))
                  + PCNT_W'(push[PORT_B] && (in_ent[PORT_B].rd == ADDR_WIDTH'(r)))
                  - PCNT_W'(pop[PORT_A]  && (head[PORT_A].rd   == ADDR_WIDTH'(r)))
                  - PCNT_W'(pop[PORT_B]  && (head[PORT_B].rd   == ADDR_WIDTH'(r)));
        pend_d[r] = (pcnt_d[r] != '0);
      end
    end
  end

  // Pending counters and registered mask, updated on the push/pop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= '0;
      pend_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= pcnt_d[r];
      pend_q <= pend_d;
    end
  end

  assign pend_mask = pend_q;
`else
  assign pend_mask = '0;
`endif

  // Producers must hold rd/data steady while stalled.
  a_hold_chk: assert property (@(posedge clk) disable iff (rst)
    (a_valid && !a_ready) |=> (!a_valid || ($stable(a_rd) && $stable(a_data))));
  b_hold_chk: assert property (@(posedge clk) disable iff (rst)
    (b_valid && !b_ready) |=> (!b_valid || ($stable(b_rd) && $stable(b_data))));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset state, single write latency,
// round-robin interleave, backpressure with FIFO wrap, x0 writes, the
// pending mask and reset mid-operation. Works with or without WBARB_PEND_EN.
module tb_wb_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_rd, b_rd;
  logic [DW-1:0] a_data, b_data;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] pend_mask;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic pend_en;
  int   ia, ib;
  logic acc_a, acc_b;

  // Expected write order and b_ready per edge for the backpressure test.
  int exp_out  [13] = '{20, 2, 21, 3, 22, 4, 23, 5, 24, 6, 25, 7, 8};
  int exp_brdy [15] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};

  wb_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected pend_mask: the given bits when the feature is built, else zero.
  function automatic logic [NR-1:0] pexp(input logic [NR-1:0] m);
    return pend_en ? m : '0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef WBARB_PEND_EN
    pend_en = 1'b1;
`else
    pend_en = 1'b0;
`endif
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;

    // Reset state, checked while reset is held and before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_we",    64'(rf_we),     64'(0));
    check("rst_addr",  64'(rf_addr),   64'(0));
    check("rst_wdata", 64'(rf_wdata),  64'(0));
    check("rst_pend",  64'(pend_mask), 64'(0));
    check("rst_ardy",  64'(a_ready),   64'(1));
    check("rst_brdy",  64'(b_ready),   64'(1));
    tick();
    tick();
    rst = 1'b0;

    // 1: single A write, popped one edge after the push.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    a_valid = 1'b0;
    check("t1_we_e0",   64'(rf_we),     64'(0));
    check("t1_pend_e0", 64'(pend_mask), 64'(pexp(32'h0000_0020)));
    tick();
    check("t1_we_e1",   64'(rf_we),     64'(1));
    check("t1_addr_e1", 64'(rf_addr),   64'(5));
    check("t1_data_e1", 64'(rf_wdata),  64'(32'hDEADBEEF));
    check("t1_pend_e1", 64'(pend_mask), 64'(0));
    tick();
    check("t1_we_e2",   64'(rf_we),     64'(0));
    check("t1_addr_e2", 64'(rf_addr),   64'(5));
    check("t1_data_e2", 64'(rf_wdata),  64'(32'hDEADBEEF));

    // 2: both ports every cycle -> 1,11,2,12,3,13,4,14 back to back.
    do_reset();
    for (int t = 0; t < 10; t++) begin
      if (t < 4) begin
        a_valid = 1'b1; a_rd = AW'(1 + t);  a_data = 32'hA000_0000 + 32'(1 + t);
        b_valid = 1'b1; b_rd = AW'(11 + t); b_data = 32'hB000_0000 + 32'(11 + t);
      end else begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      tick();
      if (t >= 1 && t <= 8) begin
        check($sformatf("t2_we_%0d", t), 64'(rf_we), 64'(1));
        if (((t - 1) % 2) == 0) begin
          check($sformatf("t2_addr_%0d", t), 64'(rf_addr),  64'(1 + (t - 1) / 2));
          check($sformatf("t2_data_%0d", t), 64'(rf_wdata), 64'(32'hA000_0000 + 32'(1 + (t - 1) / 2)));
        end else begin
          check($sformatf("t2_addr_%0d", t), 64'(rf_addr),  64'(11 + (t - 1) / 2));
          check($sformatf("t2_data_%0d", t), 64'(rf_wdata), 64'(32'hB000_0000 + 32'(11 + (t - 1) / 2)));
        end
      end else if (t == 9) begin
        check("t2_we_idle", 64'(rf_we), 64'(0));
      end
    end

    // 3: A (rd 20..25) contends with B (rd 2..8, valid held); B fills,
    // b_ready drops, the stalled entry waits and every write stays in order.
    do_reset();
    ia = 0;
    ib = 0;
    for (int t = 0; t < 15; t++) begin
      a_valid = (ia < 6);
      a_rd    = AW'(20 + ia);
      a_data  = 32'hA000_0000 + 32'(20 + ia);
      b_valid = (ib < 7);
      b_rd    = AW'(2 + ib);
      b_data  = 32'hB000_0000 + 32'(2 + ib);
      acc_a   = a_valid && a_ready;
      acc_b   = b_valid && b_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
      check($sformatf("t3_brdy_%0d", t), 64'(b_ready), 64'(exp_brdy[t]));
      if (t >= 1 && t <= 13) begin
        check($sformatf("t3_we_%0d", t),   64'(rf_we),   64'(1));
        check($sformatf("t3_addr_%0d", t), 64'(rf_addr), 64'(exp_out[t - 1]));
        if (exp_out[t - 1] >= 20)
          check($sformatf("t3_data_%0d", t), 64'(rf_wdata), 64'(32'hA000_0000 + 32'(exp_out[t - 1])));
        else
          check($sformatf("t3_data_%0d", t), 64'(rf_wdata), 64'(32'hB000_0000 + 32'(exp_out[t - 1])));
      end else if (t == 14) begin
        check("t3_we_idle", 64'(rf_we), 64'(0));
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t3_a_count", 64'(ia), 64'(6));
    check("t3_b_count", 64'(ib), 64'(7));

    // 4: x0 write is consumed silently; the next A entry follows.
    do_reset();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h0000_1234;
    tick();
    a_rd = 5'd9; a_data = 32'h0000_0055;
    check("t4_ardy_e0", 64'(a_ready), 64'(1));
    tick();
    a_valid = 1'b0;
    check("t4_we_e1",   64'(rf_we),    64'(0));
    check("t4_addr_e1", 64'(rf_addr),  64'(0));
    check("t4_data_e1", 64'(rf_wdata), 64'(32'h0000_1234));
    check("t4_ardy_e1", 64'(a_ready),  64'(1));
    tick();
    check("t4_we_e2",   64'(rf_we),    64'(1));
    check("t4_addr_e2", 64'(rf_addr),  64'(9));
    check("t4_data_e2", 64'(rf_wdata), 64'(32'h0000_0055));
    tick();
    check("t4_we_e3",   64'(rf_we),    64'(0));

    // 5: rd=7 from A then B; mask stays set until the second pop.
    do_reset();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0000_0070;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0071;
    check("t5_pend_e0", 64'(pend_mask), 64'(pexp(32'h0000_0080)));
    tick();
    b_valid = 1'b0;
    check("t5_pend_e1", 64'(pend_mask), 64'(pexp(32'h0000_0080)));
    check("t5_data_e1", 64'(rf_wdata),  64'(32'h0000_0070));
    tick();
    check("t5_pend_e2", 64'(pend_mask), 64'(0));
    check("t5_we_e2",   64'(rf_we),     64'(1));
    check("t5_data_e2", 64'(rf_wdata),  64'(32'h0000_0071));

    // 6: queue 3 entries per port, then reset mid-cycle.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      a_valid = 1'b1; a_rd = AW'(1 + t);  a_data = 32'hA000_0000 + 32'(1 + t);
      b_valid = 1'b1; b_rd = AW'(17 + t); b_data = 32'hB000_0000 + 32'(17 + t);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t6_we_pre",   64'(rf_we),     64'(1));
    check("t6_addr_pre", 64'(rf_addr),   64'(18));
    check("t6_pend_pre", 64'(pend_mask), 64'(pexp(32'h0038_0038)));
    #3 rst = 1'b1;
    #1;
    check("t6_we_rst",    64'(rf_we),     64'(0));
    check("t6_addr_rst",  64'(rf_addr),   64'(0));
    check("t6_wdata_rst", 64'(rf_wdata),  64'(0));
    check("t6_pend_rst",  64'(pend_mask), 64'(0));
    tick();
    rst = 1'b0;
    check("t6_ardy_post", 64'(a_ready), 64'(1));
    check("t6_brdy_post", 64'(b_ready), 64'(1));
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("t6_we_post_%0d", t), 64'(rf_we), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Merges register-file writeback traffic from two independent producers into the register file's single write port. Port A is the ALU/execute path and port B is the load/long-latency path. Each port is buffered in its own small FIFO, and the two FIFOs are served round-robin, one write per cycle. The block drives the regfile write-enable, write-address and write-data inputs directly from registers. An optional pending-write mask is provided for hazard logic.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, width of destination register index
NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)
FIFO_DEPTH, 4, entries per port FIFO; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
a_valid  in  1  port A write request
a_ready  out  1  port A FIFO can accept
a_rd  in  ADDR_WIDTH  port A destination register
a_data  in  DATA_WIDTH  port A write data
b_valid  in  1  port B write request
b_ready  out  1  port B FIFO can accept
b_rd  in  ADDR_WIDTH  port B destination register
b_data  in  DATA_WIDTH  port B write data
rf_we  out  1  regfile write enable (registered)
rf_addr  out  ADDR_WIDTH  regfile write address (registered)
rf_wdata  out  DATA_WIDTH  regfile write data (registered)
pend_mask  out  NUM_REGS  bit r = a write to register r is queued in either FIFO

Behaviour:
- Reset values (async, immediate): both FIFOs empty, with pointers and counts at 0. rf_we=0, rf_addr=0, rf_wdata=0, pend_mask=0. Round-robin priority is set to A.
- Reset mid-operation: all queued entries are discarded. No write is issued for them.
- Ready rules:
  - x_ready = !full_x, registered from occupancy.
  - A full FIFO deasserts ready even in a cycle where it pops; there is no pass-through.
  - x_ready does not depend on x_valid.
- Push: on any edge with x_valid && x_ready, {x_rd, x_data} is written at the tail.
  - x_rd/x_data must be held while x_valid && !x_ready. This is a producer obligation, checked by assertion.
- Arbitration (every edge):
  - Both FIFOs non-empty: the priority holder wins, and priority then passes to the other port.
  - Exactly one FIFO non-empty: that FIFO wins, and priority passes to the other port.
  - Both empty: no grant, and priority is unchanged.
- Grant:
  - The winner's head is popped.
  - rf_addr <= head.rd and rf_wdata <= head.data.
  - rf_we <= (head.rd != 0).
- x0 writes: accepted and consumed like any other entry, but rf_we stays 0.
- No grant: rf_we <= 0, and rf_addr/rf_wdata hold their previous values.
- Latency:
  - An entry pushed at edge k into an empty FIFO with priority (or no contention) is popped at edge k+1.
  - rf_we is therefore high during the cycle after edge k+1.
  - There is no same-edge push-to-output path.
- Ordering:
  - Strict FIFO order within a port.
  - No ordering guarantee between ports. Same-rd collisions across ports are resolved by the producers using pend_mask.
- Throughput: one regfile write per cycle when any FIFO is non-empty. Each port gets at least 50% of grants under contention.
- Simultaneous push and pop on the same FIFO in one edge: occupancy is unchanged and the pointers both advance.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are tracked by a separate count of width log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro WBARB_PEND_EN.
- Defined:
  - Each register r != 0 has a counter of width log2(2*FIFO_DEPTH+1).
  - The counter increments on a push targeting r and decrements on a pop targeting r. A push and pop to the same r in one edge leaves it unchanged. A push from A and a push from B to the same r in one edge adds 2.
  - pend_mask[r] = (count_r != 0) and is registered. It updates on the same edge as the push or pop.
  - pend_mask[0] is always 0.
- Not defined: pend_mask is tied to all-zeros and no counters are synthesised.

Test Plan:
1. After reset, single A push rd=5 data=0xDEADBEEF -> next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF. The cycle after that, rf_we=0 and addr/data hold.
2. A and B both valid every cycle (A rd=1..4, B rd=11..14) -> rf_addr sequence 1,11,2,12,3,13,4,14 with no idle cycles.
3. b_valid held high with no prior pops blocked, pushes rd=2..6 -> b_ready falls after 4 accepted entries. The 5th entry is held and accepted only after the first pop, and all 5 writes appear in order.
4. A push rd=0 data=0x1234 -> the entry is consumed one cycle later with rf_we=0. a_ready stays 1, and the next A entry follows normally.
5. (WBARB_PEND_EN) A push rd=7, then B push rd=7 one cycle later -> pend_mask[7]=1 after the first edge and stays 1 until the second pop. It clears on the edge that pops the last rd=7 entry.
6. 3 entries queued on A, rst asserted mid-cycle -> rf_we, rf_addr, rf_wdata and pend_mask go to 0 immediately, with no writes after rst deasserts. a_ready=1 and b_ready=1 once rst deasserts.
